// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD write controller:
// state encoding, delay-counter width, init command table and helpers.
package lcd_pkg;

    // Wide enough for the default 2.5M-cycle power-up wait.
    localparam int CNT_W = 22;

    typedef enum logic [2:0] {
        ESPERA_LIGAR = 3'd0,
        INIT_SETUP   = 3'd1,
        INIT_PULSO   = 3'd2,
        INIT_ESPERA  = 3'd3,
        OCIOSO       = 3'd4,
        ESCR_SETUP   = 3'd5,
        ESCR_PULSO   = 3'd6,
        ESCR_ESPERA  = 3'd7
    } estado_t;

    localparam logic [7:0] CMD_FUNCAO   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISPLAY  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRADA  = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_HOME     = 8'h02;

    localparam logic [1:0] ULTIMO_INIT  = 2'd3;

    // Init command sequence, indexed 0..3.
    function automatic logic [7:0] cmd_init(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = CMD_FUNCAO;
            2'd1:    c = CMD_DISPLAY;
            2'd2:    c = CMD_CLEAR;
            2'd3:    c = CMD_ENTRADA;
            default: c = CMD_FUNCAO;
        endcase
        return c;
    endfunction

    // Clear and home are the slow instructions; everything else uses the short wait.
    function automatic logic espera_longa(input logic is_cmd, input logic [7:0] b);
        return is_cmd && ((b == CMD_CLEAR) || (b == CMD_HOME));
    endfunction

endpackage

// File: rtl/controlador_lcd_if.sv
// CPU request handshake plus the LCD pin bundle.
interface controlador_lcd_if;
    logic       req;
    logic       req_is_cmd;
    logic [7:0] req_byte;
    logic       ready;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    modport master (
        output req, req_is_cmd, req_byte,
        input  ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data
    );

    modport slave (
        input  req, req_is_cmd, req_byte,
        output ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data
    );
endinterface

// File: rtl/contador_atraso.sv
// Down-counting delay timer: load value-1 on entry, done when it reaches zero.
// Holds at zero instead of wrapping.
module contador_atraso
    import lcd_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         carga_i,
    input  logic [W-1:0] valor_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    // Load on strobe, otherwise count down and saturate at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else if (carga_i) begin
            cnt_q <= valor_i;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_q <= cnt_q - W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign done_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/controlador_lcd.sv
// LCD write controller: power-up wait, four-command init, then single-byte
// writes with setup / enable pulse / post-write wait timing.
module controlador_lcd
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = 2_500_000,
    parameter int T_EN      = 25,
    parameter int T_CMD     = 2_500,
    parameter int T_CLEAR   = 100_000
) (
    input  logic               clk,
    input  logic               rst,
    controlador_lcd_if.slave   bus
);

    // The first power-up cycle is spent loading the counter, so load two less.
    localparam logic [CNT_W-1:0] LD_LIGAR = (T_POWERUP >= 2) ? CNT_W'(T_POWERUP - 2)
                                                             : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = {CNT_W{1'b0}};

    estado_t          state_q, state_d;
    logic             arm_q, arm_d;
    logic [1:0]       idx_q, idx_d;
    logic             cmd_q, cmd_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             ready_q, init_done_q, en_q;
    logic             carga_s;
    logic [CNT_W-1:0] carga_val_s;
    logic [CNT_W-1:0] ld_espera_s;
    logic             done_s;

    contador_atraso #(.W(CNT_W)) u_atraso (
        .clk     (clk),
        .rst     (rst),
        .carga_i (carga_s),
        .valor_i (carga_val_s),
        .done_o  (done_s)
    );

    assign ld_espera_s = espera_longa(cmd_q, data_q) ? LD_CLEAR : LD_CMD;

    // Next-state, latched-write and counter-load decisions.
    always_comb begin
        state_d     = state_q;
        arm_d       = arm_q;
        idx_d       = idx_q;
        cmd_d       = cmd_q;
        rs_d        = rs_q;
        data_d      = data_q;
        carga_s     = 1'b0;
        carga_val_s = {CNT_W{1'b0}};
        case (state_q)
            ESPERA_LIGAR: begin
                if (!arm_q) begin
                    arm_d       = 1'b1;
                    carga_s     = 1'b1;
                    carga_val_s = LD_LIGAR;
                end else if (done_s) begin
                    state_d     = INIT_SETUP;
                    idx_d       = 2'd0;
                    cmd_d       = 1'b1;
                    rs_d        = 1'b0;
                    data_d      = cmd_init(2'd0);
                    carga_s     = 1'b1;
                    carga_val_s = LD_SETUP;
                end else begin
                    state_d = ESPERA_LIGAR;
                end
            end
            INIT_SETUP, ESCR_SETUP: begin
                if (done_s) begin
                    state_d     = (state_q == INIT_SETUP) ? INIT_PULSO : ESCR_PULSO;
                    carga_s     = 1'b1;
                    carga_val_s = LD_EN;
                end else begin
                    state_d = state_q;
                end
            end
            INIT_PULSO, ESCR_PULSO: begin
                if (done_s) begin
                    state_d     = (state_q == INIT_PULSO) ? INIT_ESPERA : ESCR_ESPERA;
                    carga_s     = 1'b1;
                    carga_val_s = ld_espera_s;
                end else begin
                    state_d = state_q;
                end
            end
            INIT_ESPERA: begin
                if (done_s && (idx_q == ULTIMO_INIT)) begin
                    state_d = OCIOSO;
                end else if (done_s) begin
                    state_d     = INIT_SETUP;
                    idx_d       = idx_q + 2'd1;
                    data_d      = cmd_init(idx_q + 2'd1);
                    carga_s     = 1'b1;
                    carga_val_s = LD_SETUP;
                end else begin
                    state_d = INIT_ESPERA;
                end
            end
            OCIOSO: begin
                if (bus.req) begin
                    state_d     = ESCR_SETUP;
                    cmd_d       = bus.req_is_cmd;
                    rs_d        = ~bus.req_is_cmd;
                    data_d      = bus.req_byte;
                    carga_s     = 1'b1;
                    carga_val_s = LD_SETUP;
                end else begin
                    state_d = OCIOSO;
                end
            end
            ESCR_ESPERA: begin
                if (done_s) begin
                    state_d = OCIOSO;
                end else begin
                    state_d = ESCR_ESPERA;
                end
            end
            default: begin
                state_d = ESPERA_LIGAR;
                arm_d   = 1'b0;
            end
        endcase
    end

    // State, latched write and registered pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ESPERA_LIGAR;
            arm_q       <= 1'b0;
            idx_q       <= 2'd0;
            cmd_q       <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_d;
            idx_q       <= idx_d;
            cmd_q       <= cmd_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            ready_q     <= (state_d == OCIOSO);
            init_done_q <= init_done_q | (state_d == OCIOSO);
            en_q        <= (state_d == INIT_PULSO) || (state_d == ESCR_PULSO);
        end
    end

    assign bus.ready     = ready_q;
    assign bus.init_done = init_done_q;
    assign bus.lcd_rs    = rs_q;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_en    = en_q;
    assign bus.lcd_data  = data_q;

endmodule

// File: tb/tb_controlador_lcd.sv
// Directed self-checking bench for controlador_lcd with a scoreboard of
// expected {rs, data} values popped on every lcd_en rising edge.
module tb_controlador_lcd;

    localparam int T_POWERUP  = 20;
    localparam int T_EN       = 4;
    localparam int T_CMD      = 10;
    localparam int T_CLEAR    = 30;
    localparam int W_SHORT    = 1 + T_EN + T_CMD;
    localparam int W_LONG     = 1 + T_EN + T_CLEAR;
    localparam int INIT_TOTAL = T_POWERUP + 3 * W_SHORT + W_LONG;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    controlador_lcd_if bus();

    controlador_lcd #(
        .T_POWERUP (T_POWERUP),
        .T_EN      (T_EN),
        .T_CMD     (T_CMD),
        .T_CLEAR   (T_CLEAR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         passed = 0;
    int         fails  = 0;
    logic [8:0] exp_q[$];
    logic       prev_en = 1'b0;
    int         pulse_w = 0;
    int         pulses = 0;
    int         tick_no = 0;
    int         first_rise = -1;
    logic [8:0] rise_val = 9'h000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One clock, sampled 1 time unit after the edge, with the pin monitor inline.
    task automatic tick();
        logic [8:0] cur;
        logic [8:0] e;
        @(posedge clk);
        #1;
        tick_no++;
        if (rst) begin
            prev_en = 1'b0;
            pulse_w = 0;
        end else begin
            cur = {bus.lcd_rs, bus.lcd_data};
            if (bus.lcd_en && !prev_en) begin
                pulses++;
                pulse_w  = 1;
                rise_val = cur;
                if (first_rise < 0) first_rise = tick_no;
                chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pulse_rs_data", 32'(cur), 32'(e));
                end
                chk("lcd_rw", 32'(bus.lcd_rw), 32'd0);
            end else if (bus.lcd_en) begin
                pulse_w++;
            end else if (prev_en) begin
                chk("pulse_width", pulse_w, T_EN);
                chk("data_stable_pulse", 32'(cur), 32'(rise_val));
            end
            prev_en = bus.lcd_en;
        end
    endtask

    // Release reset and follow the full power-up/init sequence.
    task automatic do_init(input string tag);
        int n;
        int p0;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
        p0         = pulses;
        first_rise = -1;
        tick_no    = 0;
        rst        = 1'b0;
        n          = 0;
        while (bus.ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
            if (n == 50) begin
                bus.req        = 1'b1;
                bus.req_is_cmd = 1'b0;
                bus.req_byte   = 8'h55;
            end
            if (n == 51) bus.req = 1'b0;
        end
        chk({tag, "_ready_timeout"}, 32'(bus.ready), 32'd1);
        chk({tag, "_init_cycles"}, n, INIT_TOTAL);
        chk({tag, "_first_en_tick"}, first_rise, T_POWERUP + 1);
        chk({tag, "_init_done"}, 32'(bus.init_done), 32'd1);
        chk({tag, "_init_pulses"}, pulses - p0, 4);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    // One accepted write; optionally pokes req/req_byte while busy.
    task automatic write(input logic is_cmd, input logic [7:0] b, input int exp_low,
                         input bit disturb);
        int         n;
        int         p0;
        logic [8:0] e;
        e = {~is_cmd, b};
        exp_q.push_back(e);
        p0             = pulses;
        bus.req        = 1'b1;
        bus.req_is_cmd = is_cmd;
        bus.req_byte   = b;
        tick();
        bus.req = 1'b0;
        chk("accept_ready_low", 32'(bus.ready), 32'd0);
        n = 0;
        while (bus.ready !== 1'b1 && n < 1000) begin
            n++;
            if (disturb && n == 3) begin
                bus.req        = 1'b1;
                bus.req_byte   = 8'h99;
                bus.req_is_cmd = ~is_cmd;
            end
            if (disturb && n == 4) bus.req = 1'b0;
            tick();
        end
        chk("ready_low_cycles", n, exp_low);
        chk("held_rs_data", 32'({bus.lcd_rs, bus.lcd_data}), 32'(e));
        chk("one_pulse", pulses - p0, 1);
    endtask

    initial begin
        int n;
        int p0;

        // Reset, with a request that must be ignored.
        rst            = 1'b1;
        bus.req        = 1'b1;
        bus.req_is_cmd = 1'b0;
        bus.req_byte   = 8'hA5;
        repeat (3) tick();
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_init_done", 32'(bus.init_done), 32'd0);
        chk("rst_en", 32'(bus.lcd_en), 32'd0);
        chk("rst_rs", 32'(bus.lcd_rs), 32'd0);
        chk("rst_rw", 32'(bus.lcd_rw), 32'd0);
        chk("rst_data", 32'(bus.lcd_data), 32'h00);
        bus.req = 1'b0;

        do_init("init1");

        // Single writes covering short and long waits.
        write(1'b0, 8'h41, W_SHORT, 1'b0);
        write(1'b1, 8'h01, W_LONG, 1'b0);
        write(1'b1, 8'h80, W_SHORT, 1'b0);
        write(1'b1, 8'h02, W_LONG, 1'b0);
        write(1'b0, 8'h01, W_SHORT, 1'b0);
        write(1'b0, 8'h5A, W_SHORT, 1'b1);

        // Back-to-back with req held and data changed mid-write.
        p0 = pulses;
        exp_q.push_back({1'b1, 8'h41});
        bus.req        = 1'b1;
        bus.req_is_cmd = 1'b0;
        bus.req_byte   = 8'h41;
        tick();
        n = 0;
        while (bus.ready !== 1'b1 && n < 1000) begin
            n++;
            if (n == 5) begin
                bus.req_byte = 8'h42;
                exp_q.push_back({1'b1, 8'h42});
            end
            tick();
        end
        chk("b2b_first_low", n, W_SHORT);
        chk("b2b_first_held", 32'(bus.lcd_data), 32'h41);
        tick();
        chk("b2b_reaccept", 32'(bus.ready), 32'd0);
        bus.req = 1'b0;
        n = 0;
        while (bus.ready !== 1'b1 && n < 1000) begin
            n++;
            tick();
        end
        chk("b2b_second_low", n, W_SHORT);
        chk("b2b_second_data", 32'(bus.lcd_data), 32'h42);
        chk("b2b_pulses", pulses - p0, 2);

        // Reset in the middle of an enable pulse.
        exp_q.push_back({1'b1, 8'h43});
        bus.req        = 1'b1;
        bus.req_is_cmd = 1'b0;
        bus.req_byte   = 8'h43;
        tick();
        bus.req = 1'b0;
        n = 0;
        while (bus.lcd_en !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("reached_pulse", 32'(bus.lcd_en), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_en", 32'(bus.lcd_en), 32'd0);
        chk("abort_ready", 32'(bus.ready), 32'd0);
        chk("abort_init_done", 32'(bus.init_done), 32'd0);
        chk("abort_data", 32'(bus.lcd_data), 32'h00);
        exp_q.delete();
        tick();
        do_init("init2");
        write(1'b0, 8'h44, W_SHORT, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/controlador_lcd.md
CONTROLADOR_LCD -- requirements
Module: controlador_lcd

Interface
REQ-001 Parameter T_POWERUP, default 2_500_000, power-up wait in clk cycles before the first init command.
REQ-002 Parameter T_EN, default 25, lcd_en high width in cycles (≥1).
REQ-003 Parameter T_CMD, default 2_500, post-write wait in cycles for ordinary commands and data.
REQ-004 Parameter T_CLEAR, default 100_000, post-write wait in cycles for clear (0x01) and home (0x02) commands.
REQ-005 clk  in  1  single system clock; all logic on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req  in  1  write request from the CPU FSM; sampled only while ready=1.
REQ-008 req_is_cmd  in  1  1 = command (RS=0), 0 = character data (RS=1).
REQ-009 req_byte  in  8  byte to write.
REQ-010 ready  out  1  1 = idle, initialised, request will be accepted this cycle.
REQ-011 init_done  out  1  1 = power-up init sequence finished; sticky until rst.
REQ-012 lcd_rs  out  1  LCD register select.
REQ-013 lcd_rw  out  1  LCD read/write; constant 0 (write only).
REQ-014 lcd_en  out  1  LCD enable strobe.
REQ-015 lcd_data  out  8  LCD data bus, 8-bit mode.

Function
REQ-016 States SHALL be: ESPERA_LIGAR (power-up wait), INIT_SETUP, INIT_PULSO, INIT_ESPERA, OCIOSO, ESCR_SETUP, ESCR_PULSO, ESCR_ESPERA.
REQ-017 ESPERA_LIGAR SHALL hold lcd_en=0 for T_POWERUP cycles, then go to INIT_SETUP with init index 0.
REQ-018 Init SHALL send the commands 0x38, 0x0C, 0x01, 0x06 in that order (RS=0), each with the write timing of REQ-020..REQ-022.
REQ-019 After the wait of the 4th init command, init_done SHALL become 1, and the FSM SHALL enter OCIOSO with ready=1 in the same cycle.
REQ-020 Handshake: req=1 while ready=1 at edge N accepts the request and latches req_byte and req_is_cmd; from N+1, ready=0 and the FSM is in ESCR_SETUP.
REQ-021 SETUP lasts 1 cycle, with lcd_rs=~is_cmd and lcd_data=byte valid and lcd_en=0; PULSO then holds lcd_en=1 for exactly T_EN cycles.
REQ-022 ESPERA holds lcd_en=0 for T_CLEAR cycles if is_cmd and byte is 0x01 or 0x02, otherwise T_CMD cycles; the FSM then returns to OCIOSO.
REQ-023 Latency: ready SHALL be low for exactly 1+T_EN+T_wait cycles per accepted write.
REQ-024 lcd_rs and lcd_data SHALL stay stable from SETUP through the end of ESPERA; changes to req_byte after acceptance SHALL have no effect.
REQ-025 req while ready=0 (init or write in progress) SHALL be ignored, with no queuing; the requester must hold req or retry.
REQ-026 Back-to-back: req held high SHALL be accepted again on the first cycle ready=1.
REQ-027 Delay counter SHALL be ≥22 bits, load the target-1 on state entry, and never wrap.

Reset
REQ-028 While rst=1: state=ESPERA_LIGAR, ready=0, init_done=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, counter=0.
REQ-029 rst asserted mid-write or mid-init SHALL abort immediately; the full power-up and init sequence SHALL restart after release.
REQ-030 req during reset SHALL be ignored.

Structure
REQ-031 The shared package lcd_pkg SHALL hold the state encoding, the init command constants (0x38/0x0C/0x01/0x06) and the clear/home codes.
REQ-032 One sub-module, contador_atraso, SHALL provide the delay counter: load value, load strobe, done flag.
REQ-033 Estimated RTL size: 150–250 lines.

Verification (T_POWERUP=20, T_EN=4, T_CMD=10, T_CLEAR=30)
REQ-034 Release rst → lcd_en stays low 20 cycles, then 4 pulses with lcd_data 0x38, 0x0C, 0x01, 0x06, RS=0; init_done=ready=1 exactly 100 cycles after release.
REQ-035 After init, req=1, is_cmd=0, byte=0x41 for one cycle → lcd_rs=1, lcd_data=0x41, lcd_en high 4 cycles; ready low exactly 15 cycles.
REQ-036 Command 0x01 → ready low exactly 35 cycles; command 0x80 → ready low exactly 15 cycles.
REQ-037 req pulse during init and during a busy write → no extra lcd_en pulse; the held byte is unchanged.
REQ-038 req held high with byte 0x41 then 0x42 → two writes with no idle gap beyond the ready cycle; data changed mid-write is not seen on lcd_data.
REQ-039 rst asserted during ESCR_PULSO → next cycle lcd_en=0, ready=0, init_done=0; the init sequence repeats per REQ-034.
